// File: rtl/seq_mul_arbiter_if.sv
// ---------------------------------------------------------------------------
// seq_mul_arbiter_if
// Bundles the signals between the two requesters, the arbiter and the shared
// sequential multiplier.
//   slave  : arbiter view (requests and multiplier results in; grants,
//            completions, result and multiplier command out)
//   master : environment view (requesters and the multiplier together)
// Signals:
//   req0/req1        request, held until the matching done
//   a0,b0 / a1,b1    multiplier / multiplicand operand of each requester
//   gnt0/gnt1        1-cycle grant pulse
//   done0/done1      1-cycle completion pulse, res/err valid with it
//   res, err         product (2N+1 bits) and watchdog-abort flag
//   mul_start        1-cycle start to the multiplier
//   mul_mlier/mcand  latched operands towards the multiplier
//   mul_prodt        product from the multiplier
//   mul_valid        multiplier valid level (accepted on its rising edge)
// ---------------------------------------------------------------------------
interface seq_mul_arbiter_if #(
    parameter int N = 8
);
    logic           req0;
    logic [N-1:0]   a0;
    logic [N-1:0]   b0;
    logic           req1;
    logic [N-1:0]   a1;
    logic [N-1:0]   b1;
    logic           gnt0;
    logic           gnt1;
    logic           done0;
    logic           done1;
    logic [2*N:0]   res;
    logic           err;
    logic           mul_start;
    logic [N-1:0]   mul_mlier;
    logic [N-1:0]   mul_mcand;
    logic [2*N:0]   mul_prodt;
    logic           mul_valid;

    modport slave (
        input  req0, a0, b0, req1, a1, b1, mul_prodt, mul_valid,
        output gnt0, gnt1, done0, done1, res, err,
               mul_start, mul_mlier, mul_mcand
    );

    modport master (
        output req0, a0, b0, req1, a1, b1, mul_prodt, mul_valid,
        input  gnt0, gnt1, done0, done1, res, err,
               mul_start, mul_mlier, mul_mcand
    );
endinterface

// File: rtl/seq_mul_arbiter.sv
// ---------------------------------------------------------------------------
// seq_mul_arbiter
// Shares one sequential multiplier between two requesters. Round-robin
// arbitration, operands latched at grant, a 1-cycle start, then a wait for
// the multiplier's valid rising edge (or a watchdog abort), and finally a
// done pulse with the result to the requester that won.
// Ports:
//   i_clk    clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   bus      seq_mul_arbiter_if.slave (requests, grants, results,
//            multiplier command/response)
// Parameters:
//   N        operand width (product is 2N+1 bits)
//   TIMEOUT  maximum number of WAIT cycles before abort (>= 2)
//   CW       watchdog counter width, 2**CW > TIMEOUT
// ---------------------------------------------------------------------------
module seq_mul_arbiter #(
    parameter int N       = 8,
    parameter int TIMEOUT = 64,
    parameter int CW      = 7
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    seq_mul_arbiter_if.slave     bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t         r_state;
    logic           r_last;      // owner of the most recent completed op
    logic           r_owner;     // owner of the op in flight
    logic [CW-1:0]  r_cnt;
    logic           r_valid_q;
    logic           r_gnt0;
    logic           r_gnt1;
    logic           r_done0;
    logic           r_done1;
    logic           r_start;
    logic           r_err;
    logic [2*N:0]   r_res;
    logic [N-1:0]   r_mlier;
    logic [N-1:0]   r_mcand;

    // Only a fresh rising edge counts, so a valid still high from an earlier
    // (or reset-orphaned) operation is never taken as this one's result.
    logic           w_valid_rise;
    assign w_valid_rise = bus.mul_valid & ~r_valid_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_last    <= 1'b1;
            r_owner   <= 1'b0;
            r_cnt     <= '0;
            r_valid_q <= 1'b0;
            r_gnt0    <= 1'b0;
            r_gnt1    <= 1'b0;
            r_done0   <= 1'b0;
            r_done1   <= 1'b0;
            r_start   <= 1'b0;
            r_err     <= 1'b0;
            r_res     <= '0;
            r_mlier   <= '0;
            r_mcand   <= '0;
        end else begin
            r_valid_q <= bus.mul_valid;
            r_gnt0    <= 1'b0;
            r_gnt1    <= 1'b0;
            r_done0   <= 1'b0;
            r_done1   <= 1'b0;
            r_start   <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    // On a tie r_last picks the other requester.
                    if (bus.req0 && (!bus.req1 || r_last)) begin
                        r_gnt0  <= 1'b1;
                        r_owner <= 1'b0;
                        r_mlier <= bus.a0;
                        r_mcand <= bus.b0;
                        r_err   <= 1'b0;
                        r_state <= S_ISSUE;
                    end else if (bus.req1) begin
                        r_gnt1  <= 1'b1;
                        r_owner <= 1'b1;
                        r_mlier <= bus.a1;
                        r_mcand <= bus.b1;
                        r_err   <= 1'b0;
                        r_state <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    r_start <= 1'b1;
                    r_cnt   <= '0;
                    r_state <= S_WAIT;
                end

                S_WAIT: begin
                    if (w_valid_rise) begin
                        r_res   <= bus.mul_prodt;
                        r_err   <= 1'b0;
                        r_done0 <= ~r_owner;
                        r_done1 <= r_owner;
                        r_state <= S_RESP;
                    end else if (r_cnt == CNT_LAST) begin
                        r_res   <= '0;
                        r_err   <= 1'b1;
                        r_done0 <= ~r_owner;
                        r_done1 <= r_owner;
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_RESP: begin
                    r_last  <= r_owner;
                    r_state <= S_IDLE;
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.gnt0      = r_gnt0;
    assign bus.gnt1      = r_gnt1;
    assign bus.done0     = r_done0;
    assign bus.done1     = r_done1;
    assign bus.res       = r_res;
    assign bus.err       = r_err;
    assign bus.mul_start = r_start;
    assign bus.mul_mlier = r_mlier;
    assign bus.mul_mcand = r_mcand;

endmodule
